// File: rtl/gpr.sv
`default_nettype none
// ============================================================================
// Module  : gpr
// Brief   : 32x32 MIPS general-purpose register file, one synchronous write
//           port, two combinational read ports, register 0 hardwired to zero.
//           Optional write-to-read forwarding when GPR_BYPASS_EN is defined.
// Revision: 1.0 - initial release
// ============================================================================
module gpr #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [ADDR_W-1:0] raddr1,
    input  logic [ADDR_W-1:0] raddr2,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2
);

    localparam int c_NREGS = 2 ** ADDR_W;

    logic [DATA_W-1:0] r_regs [c_NREGS];
    logic [ADDR_W-1:0] w_raddr [2];
    logic [DATA_W-1:0] w_rdata [2];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < c_NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (we && (waddr != '0)) begin
            r_regs[waddr] <= wdata;
        end
    end

    assign w_raddr[0] = raddr1;
    assign w_raddr[1] = raddr2;

    generate
        for (genvar p = 0; p < 2; p++) begin : g_rdport
            logic [DATA_W-1:0] w_stored;

            assign w_stored = (w_raddr[p] == '0) ? '0 : r_regs[w_raddr[p]];

`ifdef GPR_BYPASS_EN
            // Forward the in-flight write so writeback can feed decode in the same cycle
            logic w_fwd;
            assign w_fwd = we && !reset && (waddr != '0) && (w_raddr[p] == waddr);
            assign w_rdata[p] = w_fwd ? wdata : w_stored;
`else
            assign w_rdata[p] = w_stored;
`endif
        end
    endgenerate

    assign rdata1 = w_rdata[0];
    assign rdata2 = w_rdata[1];

endmodule
`default_nettype wire

// File: tb/tb_gpr.sv
`default_nettype none
// ============================================================================
// Module  : tb_gpr
// Brief   : Scoreboard bench for gpr; stimulus queues expected read data and a
//           negedge monitor pops and compares against both read ports.
// Revision: 1.0 - initial release
// ============================================================================
module tb_gpr;

    localparam int c_DW = 32;
    localparam int c_AW = 5;

    logic            clk;
    logic            reset;
    logic            we;
    logic [c_AW-1:0] waddr;
    logic [c_AW-1:0] raddr1;
    logic [c_AW-1:0] raddr2;
    logic [c_DW-1:0] wdata;
    logic [c_DW-1:0] rdata1;
    logic [c_DW-1:0] rdata2;

    typedef struct {
        string           name;
        logic [c_DW-1:0] e1;
        logic [c_DW-1:0] e2;
    } exp_t;

    exp_t q_exp[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    gpr #(.DATA_W(c_DW), .ADDR_W(c_AW)) dut (
        .clk   (clk),
        .reset (reset),
        .we    (we),
        .waddr (waddr),
        .raddr1(raddr1),
        .raddr2(raddr2),
        .wdata (wdata),
        .rdata1(rdata1),
        .rdata2(rdata2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: read ports are combinational, so sample mid-cycle
    always @(negedge clk) begin
        if (q_exp.size() > 0) begin
            exp_t e;
            e = q_exp.pop_front();
            n_tests++;
            if (rdata1 !== e.e1) begin
                n_fail++;
                $display("FAIL %s rdata1: got 0x%08h expected 0x%08h", e.name, rdata1, e.e1);
            end
            n_tests++;
            if (rdata2 !== e.e2) begin
                n_fail++;
                $display("FAIL %s rdata2: got 0x%08h expected 0x%08h", e.name, rdata2, e.e2);
            end
        end
    end

    // All tasks start and end 1 time unit after a rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [c_AW-1:0] a, input logic [c_DW-1:0] d);
        we = 1'b1; waddr = a; wdata = d;
        step();
        we = 1'b0;
    endtask

    task automatic chk(input string nm, input logic [c_AW-1:0] a1, input logic [c_AW-1:0] a2,
                       input logic [c_DW-1:0] e1, input logic [c_DW-1:0] e2);
        exp_t e;
        raddr1 = a1; raddr2 = a2;
        e.name = nm; e.e1 = e1; e.e2 = e2;
        q_exp.push_back(e);
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        reset = 1'b1; we = 1'b0; waddr = '0; raddr1 = '0; raddr2 = '0; wdata = '0;
        step(); step();
        reset = 1'b0;

        // Reset clears previously written registers
        wr(5'd1, 32'hA1);
        wr(5'd2, 32'hA2);
        wr(5'd3, 32'hA3);
        chk("pre_reset_r1", 5'd1, 5'd3, 32'hA1, 32'hA3);
        reset = 1'b1;
        step(); step();
        reset = 1'b0;
        for (int i = 0; i < 32; i++) begin
            chk($sformatf("reset_r%0d", i), 5'(i), 5'(31 - i), '0, '0);
        end

        // Sequential write / read-back on both ports
        wr(5'd1, 32'd5); chk("seq_r1", 5'd1, 5'd1, 32'd5, 32'd5);
        wr(5'd2, 32'd7); chk("seq_r2", 5'd2, 5'd2, 32'd7, 32'd7);
        wr(5'd3, 32'd9); chk("seq_r3", 5'd3, 5'd3, 32'd9, 32'd9);
        chk("seq_r1_r3", 5'd1, 5'd3, 32'd5, 32'd9);

        // Register zero ignores writes
        wr(5'd0, 32'hDEADBEEF);
        chk("r0_after_write", 5'd0, 5'd0, '0, '0);
        wr(5'd1, 32'h1234);
        chk("r1_1234", 5'd1, 5'd0, 32'h1234, '0);

        // we=0 holds contents
        wr(5'd4, 32'h11);
        we = 1'b0; waddr = 5'd4; wdata = 32'h22;
        step(); step(); step();
        chk("we0_hold_r4", 5'd4, 5'd4, 32'h11, 32'h11);

        // Reset beats a same-edge write; read during that cycle sees no forwarding
        reset = 1'b1; we = 1'b1; waddr = 5'd5; wdata = 32'hAA;
        raddr1 = 5'd5; raddr2 = 5'd4;
        e.name = "rst_cycle_read"; e.e1 = '0; e.e2 = 32'h11;
        q_exp.push_back(e);
        step();
        reset = 1'b0; we = 1'b0;
        chk("rst_prio_r5", 5'd5, 5'd4, '0, '0);

        // Same-cycle read/write on r6
        wr(5'd6, 32'h10);
        chk("r6_old", 5'd6, 5'd6, 32'h10, 32'h10);
        we = 1'b1; waddr = 5'd6; wdata = 32'h20;
        raddr1 = 5'd6; raddr2 = 5'd7;
        e.name = "r6_same_cycle";
`ifdef GPR_BYPASS_EN
        e.e1 = 32'h20;
`else
        e.e1 = 32'h10;
`endif
        e.e2 = '0;
        q_exp.push_back(e);
        step();
        we = 1'b0;
        chk("r6_after_edge", 5'd6, 5'd6, 32'h20, 32'h20);

        // Address 31 is an ordinary register
        wr(5'd31, 32'hCAFEF00D);
        chk("r31", 5'd31, 5'd6, 32'hCAFEF00D, 32'h20);
        chk("r30_r31", 5'd30, 5'd31, '0, 32'hCAFEF00D);

        // Let the monitor drain
        for (int k = 0; k < 4 && q_exp.size() > 0; k++) step();
        if (q_exp.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", q_exp.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/gpr.md
Name: gpr

Overview:
- General-purpose register file for the 5-stage MIPS core.
- 32 architectural registers of 32 bits each.
- One synchronous write port and two asynchronous (combinational) read ports, used for rs and rt operand fetch in decode.
- Register 0 is hardwired to zero.

Parameters:
- DATA_W, 32, register and data-port width in bits.
- ADDR_W, 5, register-address width; register count is 2**ADDR_W (32).

Ports:
- clk  input  1  system clock; all state updates occur on the rising edge.
- reset  input  1  synchronous, active-high reset; clears every register.
- we  input  1  write enable for the write port.
- waddr  input  ADDR_W  write register index.
- raddr1  input  ADDR_W  read port 1 register index (rs).
- raddr2  input  ADDR_W  read port 2 register index (rt).
- wdata  input  DATA_W  write data.
- rdata1  output  DATA_W  read port 1 data.
- rdata2  output  DATA_W  read port 2 data.

Positional port order is exactly as listed: clk, reset, we, waddr, raddr1, raddr2, wdata, rdata1, rdata2.

Behaviour:
- Storage: array of 2**ADDR_W registers, each DATA_W bits.
- Reset:
  - Takes effect on a rising clk edge while reset=1; every register becomes 0.
  - After that edge, rdata1=rdata2=0 for all addresses.
  - Reset has priority over a write in the same cycle; the write is discarded.
- Before the first reset edge, register contents are undefined. Reads of register 0 still return 0.
- Write:
  - On a rising clk edge with reset=0 and we=1, regs[waddr] <= wdata.
  - With we=0, no register changes.
  - Writes to waddr=0 are ignored; register 0 always reads 0.
- Read:
  - Purely combinational: rdata1 = (raddr1==0) ? 0 : regs[raddr1]; rdata2 likewise from raddr2.
  - Zero-cycle latency. Outputs change within the same cycle as address changes and immediately after the clock edge that updates the addressed register.
  - Both ports are independent. Identical addresses on both ports return identical data.
- Read/write same address, same cycle (feature disabled):
  - Read returns the old value until the rising edge, then the new value.
- Address 31 is a normal register; no wrap or special meaning.
- No X-propagation masking beyond register 0.

Optional Feature:
- Macro: GPR_BYPASS_EN.
- Defined: write-to-read forwarding.
  - If we=1, reset=0, waddr!=0 and raddrN==waddr, then rdataN = wdata combinationally in the same cycle, before the edge.
  - Lets the writeback stage feed decode without a half-cycle write.
  - Register 0 still reads 0.
  - Forwarding is suppressed while reset=1.
- Undefined: no forwarding; read data reflects only stored register contents.

Test Plan:
- Reset: write regs 1..3 with nonzero values, then hold reset=1 for 2 edges. Required: rdata1/rdata2 = 0 for addresses 0..31.
- Sequential write/read-back: after reset, write 5 to r1, 7 to r2, 9 to r3 (we toggling each cycle, wdata incrementing). Set raddr1=raddr2 to the previously written address. Required: both outputs show 5, 7, 9 respectively, same value on both ports.
- Register zero: we=1, waddr=0, wdata=0xDEADBEEF. Required: rdata for raddr=0 stays 0. Independently, r1 written with 0x1234 reads 0x1234.
- we=0 hold: r4=0x11; apply waddr=4, wdata=0x22, we=0 for 3 edges. Required: r4 reads 0x11.
- Reset-vs-write priority: reset=1 and we=1, waddr=5, wdata=0xAA on the same edge. Required: r5 reads 0 afterwards.
- Same-cycle read/write on r6 (old value 0x10, new 0x20):
  - Without GPR_BYPASS_EN: rdata1=0x10 before the edge, 0x20 after.
  - With GPR_BYPASS_EN: 0x20 before the edge.
